// File: rtl/lock_ctrl.sv
// -----------------------------------------------------------------------------
// lock_ctrl -- control unit for the digital-lock datapath.
//
// Sequences one key entry at a time through load, compare, open, fail and
// lockout, drives the datapath strobes and produces unlock/alarm.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   key_valid  in   one-cycle pulse: datapath data_in holds an entered code
//   equal      in   datapath: entry register matches stored code
//   not_equal  in   datapath: entry register differs from stored code
//   lte        in   datapath: attempt count <= limit
//   gt         in   datapath: attempt count >  limit
//   ldep       out  load strobe for the entry register
//   clep       out  clear strobe for the entry register
//   incc       out  increment strobe for the attempt counter
//   unlock     out  lock open
//   alarm      out  lockout active
//   busy       out  FSM is working on an entry; key_valid is ignored
//
// Handshake: key_valid is a fire-and-forget pulse with no ready. It is taken
// only when sampled in IDLE; pulses in any other state (including the CLR
// cycle that precedes IDLE) are dropped, never queued.
//
// Optional build macro: LOCK_TIMED_LOCKOUT_EN
//   defined   -> LOCK ends after LOCKOUT_CYCLES cycles and returns via CLR
//   undefined -> LOCK is terminal until rst_n is asserted
//
// All outputs are registered Moore outputs: each is decoded from the next
// state and flopped, so every output is a flop with a clean reset value.
// -----------------------------------------------------------------------------
module lock_ctrl #(
  parameter int unsigned OPEN_CYCLES    = 16,
  parameter int unsigned LOCKOUT_CYCLES = 64,
  parameter int unsigned TMR_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_valid,
  input  logic equal,
  input  logic not_equal,
  input  logic lte,
  input  logic gt,
  output logic ldep,
  output logic clep,
  output logic incc,
  output logic unlock,
  output logic alarm,
  output logic busy
);

  typedef enum logic [2:0] {
    S_CLR  = 3'd0,
    S_IDLE = 3'd1,
    S_LOAD = 3'd2,
    S_CMP  = 3'd3,
    S_OPEN = 3'd4,
    S_FAIL = 3'd5,
    S_CHK  = 3'd6,
    S_LOCK = 3'd7
  } state_e;

  localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);

`ifdef LOCK_TIMED_LOCKOUT_EN
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
`else
  // The lockout length only matters when the lockout is timed.
  logic unused_lockout_cfg;
  assign unused_lockout_cfg = ^LOCKOUT_CYCLES;
`endif

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ldep_q, ldep_d;
  logic             clep_q, clep_d;
  logic             incc_q, incc_d;
  logic             unlock_q, unlock_d;
  logic             alarm_q, alarm_d;
  logic             busy_q, busy_d;
  logic             count_en;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLR:  state_d = S_IDLE;
      S_IDLE: if (key_valid) state_d = S_LOAD;
      S_LOAD: state_d = S_CMP;
      // Only a clean equal/not_equal pair opens; any illegal pair fails.
      S_CMP:  state_d = (equal && !not_equal) ? S_OPEN : S_FAIL;
      S_OPEN: if (timer_q == OPEN_LAST) state_d = S_CLR;
      S_FAIL: state_d = S_CHK;
      // Only a clean lte/gt pair releases; any illegal pair locks.
      S_CHK:  state_d = (lte && !gt) ? S_CLR : S_LOCK;
`ifdef LOCK_TIMED_LOCKOUT_EN
      S_LOCK: if (timer_q == LOCK_LAST) state_d = S_CLR;
`else
      S_LOCK: state_d = S_LOCK;
`endif
      default: state_d = S_CLR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timer: restarts from zero on every state entry, counts only in timed
  // states. It never wraps because each timed state exits at its last count.
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef LOCK_TIMED_LOCKOUT_EN
    count_en = (state_q == S_OPEN) || (state_q == S_LOCK);
`else
    count_en = (state_q == S_OPEN);
`endif
    timer_d = '0;
    if (count_en && (state_d == state_q)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, flopped below.
  // busy is low in CLR as well as IDLE so that reset leaves it low.
  // ---------------------------------------------------------------------------
  always_comb begin
    ldep_d   = (state_d == S_LOAD);
    clep_d   = (state_d == S_CLR);
    incc_d   = (state_d == S_FAIL);
    unlock_d = (state_d == S_OPEN);
    alarm_d  = (state_d == S_LOCK);
    busy_d   = !((state_d == S_IDLE) || (state_d == S_CLR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_CLR;
      timer_q  <= '0;
      ldep_q   <= 1'b0;
      clep_q   <= 1'b1;
      incc_q   <= 1'b0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ldep_q   <= ldep_d;
      clep_q   <= clep_d;
      incc_q   <= incc_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
      busy_q   <= busy_d;
    end
  end

  assign ldep   = ldep_q;
  assign clep   = clep_q;
  assign incc   = incc_q;
  assign unlock = unlock_q;
  assign alarm  = alarm_q;
  assign busy   = busy_q;

endmodule
